// File: rtl/gshare_bp_pkg.sv
// gshare_bp_pkg: shared widths, counter/history types and the saturating counter step.
package gshare_bp_pkg;
  localparam int INSTR_MEM_IDX_W = 10;
  localparam int PHT_IDX_W = 6;
  localparam int BP_GHR_W = 4;
  localparam int BP_CTR_W = 2;
  localparam int BP_CNT_W = 16;
  typedef logic [BP_CTR_W-1:0] bp_ctr_t;
  typedef logic [BP_GHR_W-1:0] bp_ghr_t;
  // Width-generic so non-default counter widths reuse it; callers truncate to their width.
  function automatic logic [31:0] bp_ctr_next(input logic [31:0] ctr, input logic taken,
                                              input int unsigned w = BP_CTR_W);
    logic [31:0] top;
    top = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return taken ? ((ctr >= top) ? top : ctr + 32'd1) : ((ctr == '0) ? '0 : ctr - 32'd1);
  endfunction
endpackage

// File: rtl/gshare_bp_if.sv
// gshare_bp_if: fetch-side prediction, resolve-side training and perf outputs of the predictor.
interface gshare_bp_if
  import gshare_bp_pkg::*;
#(
  parameter int PC_W  = INSTR_MEM_IDX_W,
  parameter int GHR_W = BP_GHR_W,
  parameter int CNT_W = BP_CNT_W
);
  logic             fetch_valid;
  logic             fetch_is_br;
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispred;
  logic [CNT_W-1:0] perf_pred;
  logic [CNT_W-1:0] perf_misp;
  modport master (
    output fetch_valid, fetch_is_br, fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred,
    input  pred_taken, pred_ghr, perf_pred, perf_misp
  );
  modport slave (
    input  fetch_valid, fetch_is_br, fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred,
    output pred_taken, pred_ghr, perf_pred, perf_misp
  );
endinterface

// File: rtl/gshare_bp_ghr.sv
// bp_ghr: speculative global history with mispredict repair; repair wins over a same-cycle shift.
module bp_ghr
  import gshare_bp_pkg::*;
#(
  parameter int GHR_W = BP_GHR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spec_en,
  input  logic             spec_bit,
  input  logic             fix_en,
  input  logic [GHR_W-1:0] fix_ghr,
  input  logic             fix_bit,
  output logic [GHR_W-1:0] ghr
);
  logic [GHR_W-1:0] ghr_q, ghr_d, spec_nxt, fix_nxt;
  logic unused_fix;
  assign unused_fix = ^fix_ghr;
  if (GHR_W == 1) begin : g_one
    assign spec_nxt = spec_bit;
    assign fix_nxt  = fix_bit;
  end else begin : g_shift
    assign spec_nxt = {ghr_q[GHR_W-2:0], spec_bit};
    assign fix_nxt  = {fix_ghr[GHR_W-2:0], fix_bit};
  end
  always_comb ghr_d = fix_en ? fix_nxt : spec_en ? spec_nxt : ghr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ghr_q <= '0;
    else ghr_q <= ghr_d;
  assign ghr = ghr_q;
endmodule

// File: rtl/gshare_bp.sv
// gshare_bp: gshare/bimodal direction predictor with zero-latency lookup, resolve-time training and perf counters.
module gshare_bp
  import gshare_bp_pkg::*;
#(
  parameter int PC_W   = INSTR_MEM_IDX_W,
  parameter int IDX_W  = PHT_IDX_W,
  parameter int GHR_W  = BP_GHR_W,
  parameter int CTR_W  = BP_CTR_W,
  parameter int GSHARE = 1,
  parameter int CNT_W  = BP_CNT_W
) (
  input logic        clk,
  input logic        rst,
  gshare_bp_if.slave bp
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  logic [CTR_W-1:0] pht_q [DEPTH];
  logic [CTR_W-1:0] pht_d [DEPTH];
  logic [CNT_W-1:0] perf_pred_q, perf_pred_d, perf_misp_q, perf_misp_d;
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic pred_taken, pred_ev, misp_ev;
  logic unused_pc;
  function automatic logic [IDX_W-1:0] hash(input logic [PC_W-1:0] pc, input logic [GHR_W-1:0] g);
    return pc[IDX_W-1:0] ^ ((GSHARE != 0) ? IDX_W'(g) : '0);
  endfunction
  assign unused_pc  = ^{bp.fetch_pc, bp.upd_pc};
  assign fetch_idx  = hash(bp.fetch_pc, ghr);
  assign upd_idx    = hash(bp.upd_pc, bp.upd_ghr);
  // Lookup reads the registered table, so a same-cycle train on this entry is seen next cycle.
  assign pred_taken = pht_q[fetch_idx][CTR_W-1];
  assign pred_ev    = bp.fetch_valid & bp.fetch_is_br;
  assign misp_ev    = bp.upd_valid & bp.upd_mispred;
  always_comb begin
    pht_d = pht_q;
    if (bp.upd_valid) pht_d[upd_idx] = CTR_W'(bp_ctr_next(32'(pht_q[upd_idx]), bp.upd_taken, CTR_W));
    perf_pred_d = (pred_ev && !(&perf_pred_q)) ? perf_pred_q + 1'b1 : perf_pred_q;
    perf_misp_d = (misp_ev && !(&perf_misp_q)) ? perf_misp_q + 1'b1 : perf_misp_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CTR_INIT;
      perf_pred_q <= '0;
      perf_misp_q <= '0;
    end else begin
      pht_q       <= pht_d;
      perf_pred_q <= perf_pred_d;
      perf_misp_q <= perf_misp_d;
    end
  bp_ghr #(.GHR_W(GHR_W)) u_ghr (
    .clk     (clk),
    .rst     (rst),
    .spec_en (pred_ev),
    .spec_bit(pred_taken),
    .fix_en  (misp_ev),
    .fix_ghr (bp.upd_ghr),
    .fix_bit (bp.upd_taken),
    .ghr     (ghr)
  );
  assign bp.pred_taken = pred_taken;
  assign bp.pred_ghr   = ghr;
  assign bp.perf_pred  = perf_pred_q;
  assign bp.perf_misp  = perf_misp_q;
endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: gshare and bimodal instances driven in lockstep, checked against a table/array model.
module tb_gshare_bp;
  logic clk, rst, chk_en;
  logic fv, fbr, uv, utk, um;
  logic [9:0] fpc, upc;
  logic [3:0] ughr;
  int checks = 0, failures = 0;
  int pht [2][64];
  int ghr [2];
  int np, nm;

  gshare_bp_if #(.PC_W(10), .GHR_W(4), .CNT_W(16)) ifg ();
  gshare_bp_if #(.PC_W(10), .GHR_W(4), .CNT_W(16)) ifb ();
  assign ifg.fetch_valid = fv;  assign ifb.fetch_valid = fv;
  assign ifg.fetch_is_br = fbr; assign ifb.fetch_is_br = fbr;
  assign ifg.fetch_pc    = fpc; assign ifb.fetch_pc    = fpc;
  assign ifg.upd_valid   = uv;  assign ifb.upd_valid   = uv;
  assign ifg.upd_pc      = upc; assign ifb.upd_pc      = upc;
  assign ifg.upd_ghr     = ughr; assign ifb.upd_ghr    = ughr;
  assign ifg.upd_taken   = utk; assign ifb.upd_taken   = utk;
  assign ifg.upd_mispred = um;  assign ifb.upd_mispred = um;

  gshare_bp #(.PC_W(10), .IDX_W(6), .GHR_W(4), .CTR_W(2), .GSHARE(1), .CNT_W(16))
    dut_g (.clk(clk), .rst(rst), .bp(ifg));
  gshare_bp #(.PC_W(10), .IDX_W(6), .GHR_W(4), .CTR_W(2), .GSHARE(0), .CNT_W(16))
    dut_b (.clk(clk), .rst(rst), .bp(ifb));

  logic [1:0] pt;
  logic [3:0] pg [2];
  logic [15:0] pp [2];
  logic [15:0] pm [2];
  assign pt = {ifb.pred_taken, ifg.pred_taken};
  assign pg[0] = ifg.pred_ghr;  assign pg[1] = ifb.pred_ghr;
  assign pp[0] = ifg.perf_pred; assign pp[1] = ifb.perf_pred;
  assign pm[0] = ifg.perf_misp; assign pm[1] = ifb.perf_misp;

  initial clk = 0;
  always #5 clk = ~clk;

  // d=0 is the gshare instance, d=1 the bimodal one.
  function automatic int midx(int d, int pc, int g);
    return d == 0 ? ((pc ^ g) & 63) : (pc & 63);
  endfunction
  function automatic int mpred(int d);
    return pht[d][midx(d, int'(fpc), ghr[d])] >= 2 ? 1 : 0;
  endfunction
  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) pht[d][i] = 1;
      ghr[d] = 0;
    end
    np = 0;
    nm = 0;
  endtask
  task automatic mstep();
    for (int d = 0; d < 2; d++) begin
      int p, i;
      p = mpred(d);
      if (uv) begin
        i = midx(d, int'(upc), int'(ughr));
        pht[d][i] = utk ? (pht[d][i] < 3 ? pht[d][i] + 1 : 3) : (pht[d][i] > 0 ? pht[d][i] - 1 : 0);
      end
      if (uv && um) ghr[d] = ((int'(ughr) << 1) | int'(utk)) & 15;
      else if (fv && fbr) ghr[d] = ((ghr[d] << 1) | p) & 15;
    end
    if (fv && fbr && np < 65535) np++;
    if (uv && um && nm < 65535) nm++;
  endtask
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic idle();
    fv = 0; fbr = 0; fpc = 0; uv = 0; upc = 0; ughr = 0; utk = 0; um = 0;
  endtask
  task automatic drive(logic a, logic b, int c, logic d, int e, int f, logic g, logic h);
    fv = a; fbr = b; fpc = 10'(c); uv = d; upc = 10'(e); ughr = 4'(f); utk = g; um = h;
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) mstep();
    #1;
  endtask
  task automatic mid_reset();
    chk_en = 0;
    #2 rst = 1;
    mreset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_pred[%0d]", d), int'(pt[d]), 0);
      chk($sformatf("midrst_ghr[%0d]", d), int'(pg[d]), 0);
      chk($sformatf("midrst_perf_pred[%0d]", d), int'(pp[d]), 0);
      chk($sformatf("midrst_perf_misp[%0d]", d), int'(pm[d]), 0);
    end
    tick();
    rst = 0;
    idle();
    chk_en = 1;
  endtask

  always @(negedge clk)
    if (chk_en && !rst)
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_pred[%0d]", d), int'(pt[d]), mpred(d));
        chk($sformatf("model_ghr[%0d]", d), int'(pg[d]), ghr[d]);
        chk($sformatf("model_perf_pred[%0d]", d), int'(pp[d]), np);
        chk($sformatf("model_perf_misp[%0d]", d), int'(pm[d]), nm);
      end

  initial begin
    chk_en = 0;
    rst = 1;
    idle();
    mreset();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_pred", int'(pt[d]), 0);
      chk("rst_ghr", int'(pg[d]), 0);
      chk("rst_perf_pred", int'(pp[d]), 0);
      chk("rst_perf_misp", int'(pm[d]), 0);
    end
    @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    // Reset sweep: every entry weakly not taken.
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, i, 0, 0, 0, 0, 0);
      #1 chk("sweep_pred_g", int'(pt[0]), 0);
      chk("sweep_pred_b", int'(pt[1]), 0);
      tick();
    end
    // Saturate up then down on pc 5.
    drive(1, 0, 5, 1, 5, 0, 1, 0);
    tick();
    chk("model_ctr_2", pht[0][5], 2);
    tick(); tick();
    chk("model_ctr_3", pht[0][5], 3);
    uv = 0;
    #1 chk("sat_taken_g", int'(pt[0]), 1);
    chk("sat_taken_b", int'(pt[1]), 1);
    drive(1, 0, 5, 1, 5, 0, 0, 0);
    repeat (4) tick();
    chk("model_ctr_0", pht[0][5], 0);
    uv = 0;
    #1 chk("sat_nt_g", int'(pt[0]), 0);
    chk("sat_nt_b", int'(pt[1]), 0);
    // Hash: pc 5 with history 3 lands on entry 6 under gshare only.
    drive(0, 0, 0, 1, 5, 3, 1, 0);
    tick(); tick();
    drive(1, 0, 6, 0, 0, 0, 0, 0);
    #1 chk("hash_g_e6", int'(pt[0]), 1);
    chk("hash_b_e6", int'(pt[1]), 0);
    fpc = 5;
    #1 chk("hash_g_e5", int'(pt[0]), 0);
    chk("hash_b_e5", int'(pt[1]), 1);
    tick();
    // History: entry 0 strongly taken, then three speculative shifts.
    drive(0, 0, 0, 1, 0, 0, 1, 0);
    tick(); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("hist1_b", int'(pg[1]), 1);
    chk("hist1_g", int'(pg[0]), 1);
    tick();
    chk("hist2_b", int'(pg[1]), 3);
    chk("hist2_g", int'(pg[0]), 2);
    tick();
    chk("hist3_b", int'(pg[1]), 7);
    chk("hist3_g", int'(pg[0]), 4);
    drive(1, 1, 0, 1, 0, 1, 0, 1);
    tick();
    chk("repair_g", int'(pg[0]), 2);
    chk("repair_b", int'(pg[1]), 2);
    chk("repair_misp", int'(pm[0]), 1);
    chk("repair_perf_pred", int'(pp[0]), 4);
    idle();
    // Asynchronous reset between edges, then collision on a fresh table.
    mid_reset();
    drive(1, 0, 5, 1, 5, 0, 1, 0);
    #1 chk("coll_old_g", int'(pt[0]), 0);
    chk("coll_old_b", int'(pt[1]), 0);
    tick();
    uv = 0;
    #1 chk("coll_new_g", int'(pt[0]), 1);
    chk("coll_new_b", int'(pt[1]), 1);
    tick();
    // Random traffic with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      fv   = ($urandom_range(0, 3) != 0);
      fbr  = 1'($urandom_range(0, 1));
      fpc  = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      uv   = 1'($urandom_range(0, 1));
      upc  = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      ughr = 4'($urandom);
      utk  = 1'($urandom_range(0, 1));
      um   = ($urandom_range(0, 3) == 0);
      tick();
      if (n == 1500) mid_reset();
    end
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
